// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma character defaults and the aligner state encoding.
package phy_pkg;

  localparam logic [7:0]  COMMA_DEFAULT       = 8'hBC;
  localparam int unsigned COMMA_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/rx_serial_aligner.sv
// Serial byte aligner: slides over the bit stream until COMMA_COUNT commas land
// on consecutive byte boundaries, then emits one recovered byte every 8 clocks.
module rx_serial_aligner
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA       = COMMA_DEFAULT,
  parameter int unsigned COMMA_COUNT = COMMA_COUNT_DEFAULT
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned CW = (COMMA_COUNT < 2) ? 1 : $clog2(COMMA_COUNT + 1);
  localparam logic [CW:0] CNT_TARGET = (CW+1)'(COMMA_COUNT);

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          active_q, active_d;

  logic          sr_is_comma;
  logic          boundary;
  logic [CW:0]   cnt_inc;

  assign sr_is_comma = (sr_q == COMMA);
  assign boundary    = (bit_cnt_q == 3'd0);
  // One extra bit so the target compare can never be fooled by a wrap.
  assign cnt_inc     = {1'b0, comma_cnt_q} + (CW+1)'(1);

  always_comb begin
    sr_d        = {sr_q[6:0], data_in};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    active_d    = active_q;

    case (state_q)
      ST_SEARCH: begin
        if (sr_is_comma) begin
          // Phase the bit counter so boundaries fall every 8 cycles after the hit.
          bit_cnt_d   = 3'd1;
          comma_cnt_d = CW'(1);
          state_d     = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (sr_is_comma) begin
            comma_cnt_d = cnt_inc[CW-1:0];
            if (cnt_inc >= CNT_TARGET) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          data_d   = sr_q;
          valid_d  = !sr_is_comma;
          strobe_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_rx_serial_aligner.sv
// Directed bench for rx_serial_aligner: bytes are shifted MSB first, and the
// outputs caused by a byte are captured on the first clock of the following byte.
module tb_rx_serial_aligner;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_assert = 0;
  int n_fail   = 0;
  int n_strobe;
  int n_valid;
  int lock_strobes;
  int lock_valids;

  logic [7:0] snap_data;
  logic       snap_valid;
  logic       snap_strobe;
  logic       snap_active;

  rx_serial_aligner #(
    .COMMA      (8'hBC),
    .COMMA_COUNT(4)
  ) dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_8f = ~clk_8f;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
    if (byte_strobe) n_strobe++;
    if (valid_out)   n_valid++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    n_strobe = 0;
    n_valid  = 0;
    for (int i = 7; i >= 0; i--) begin
      tick(b[i]);
      if (i == 7) begin
        snap_data   = data_out;
        snap_valid  = valid_out;
        snap_strobe = byte_strobe;
        snap_active = active;
      end
    end
  endtask

  // Checks the byte reported at the start of the byte just sent.
  task automatic check_byte(input string tag, input logic [7:0] d, input logic v);
    check({tag, " data"},   32'(snap_data),   32'(d));
    check({tag, " valid"},  32'(snap_valid),  32'(v));
    check({tag, " strobe"}, 32'(snap_strobe), 32'd1);
    check({tag, " nstrb"},  32'(n_strobe),    32'd1);
    check({tag, " held"},   32'(data_out),    32'(d));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " data"},   32'(data_out),    32'h0);
    check({tag, " valid"},  32'(valid_out),   32'd0);
    check({tag, " strobe"}, 32'(byte_strobe), 32'd0);
    check({tag, " active"}, 32'(active),      32'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick(1'b0);
    check_zero_outputs("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    do_reset(4);

    // Initial lock on four commas; nothing may be reported while aligning.
    lock_strobes = 0;
    lock_valids  = 0;
    repeat (4) begin
      send_byte(8'hBC);
      lock_strobes += n_strobe;
      lock_valids  += n_valid;
    end
    check("lock pre-active", 32'(active), 32'd0);
    check("lock strobes", 32'(lock_strobes), 32'd0);
    check("lock valids", 32'(lock_valids), 32'd0);

    send_byte(8'hBC);
    check("lock active rise", 32'(snap_active), 32'd1);
    check("lock first strobe", 32'(snap_strobe), 32'd0);
    check("lock no strobe in byte", 32'(n_strobe), 32'd0);

    send_byte(8'hBC); check_byte("stream BC#1", 8'hBC, 1'b0);
    send_byte(8'h90); check_byte("stream BC#2", 8'hBC, 1'b0);
    send_byte(8'h0A); check_byte("stream 90", 8'h90, 1'b1);
    send_byte(8'h56); check_byte("stream 0A", 8'h0A, 1'b1);
    send_byte(8'h00); check_byte("stream 56", 8'h56, 1'b1);

    // Lock at a 3-bit offset.
    do_reset(2);
    tick(1'b1); tick(1'b0); tick(1'b1);
    repeat (4) send_byte(8'hBC);
    send_byte(8'hAB);
    check("offset active", 32'(snap_active), 32'd1);
    send_byte(8'h00); check_byte("offset AB", 8'hAB, 1'b1);

    // A non-comma on a boundary during alignment drops back to searching.
    do_reset(2);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h5D);
    check("miss active", 32'(active), 32'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("miss no early lock", 32'(snap_active), 32'd0);
    send_byte(8'hBC);
    check("miss still searching", 32'(snap_active), 32'd0);
    send_byte(8'h24);
    check("miss relock", 32'(snap_active), 32'd1);
    send_byte(8'h11); check_byte("miss 24", 8'h24, 1'b1);

    // Reset mid-byte while active, then a full relock is required.
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1);
    check("pre-reset data", 32'(data_out), 32'h11);
    reset = 1'b1;
    tick(1'b0);
    check_zero_outputs("midreset");
    tick(1'b0);
    reset = 1'b0;
    lock_strobes = 0;
    repeat (3) begin
      send_byte(8'hBC);
      lock_strobes += n_strobe;
    end
    send_byte(8'hBC);
    check("relock not yet", 32'(snap_active), 32'd0);
    check("relock strobes", 32'(lock_strobes), 32'd0);
    send_byte(8'h90);
    check("relock active", 32'(snap_active), 32'd1);
    send_byte(8'h5E); check_byte("relock 90", 8'h90, 1'b1);

    // 5E,3D hides a comma across the boundary; alignment must not move.
    send_byte(8'h3D); check_byte("straddle 5E", 8'h5E, 1'b1);
    send_byte(8'h00); check_byte("straddle 3D", 8'h3D, 1'b1);
    send_byte(8'h00); check_byte("straddle 00", 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
